out_buffer_pingpong: RTL and testbench
======================================

Name: out_buffer_pingpong

Overview:
- Parametrised successor to the single-bank force output buffer.
- Holds N entries of NCH force components, each DW bits wide, in two banks (ping-pong).
- The force pipeline fills the write bank while the read bank streams to the host as DW-bit valid/ready beats.
- A COMMIT pulse swaps the banks, so frame k+1 can be written while frame k drains.

Parameters:
- N, 256, entries (bodies) per frame.
- IDX_BITS, $clog2(N), entry index width.
- DW, 16, bits per force component.
- NCH, 3, components per entry (0=X, 1=Y, 2=Z).

Ports:
- CLK_IN  in  1  clock; all logic on rising edge.
- RESET_IN  in  1  reset, synchronous, active-high.
- CLEAR  in  1  synchronous abort of the stream.
- WR_EN  in  1  write strobe.
- WR_IDX  in  IDX_BITS  entry index to write.
- WR_DATA  in  NCH*DW  packed components; channel c is WR_DATA[c*DW +: DW].
- COMMIT  in  1  current write bank is complete; request a swap.
- COMMIT_READY  out  1  high when a COMMIT will be accepted.
- DATA_OUT  out  DW  stream data.
- D_VALID  out  1  stream valid.
- D_READY  in  1  stream ready (from consumer).
- D_LAST  out  1  high on the final beat of a frame.
- FRAME_DONE  out  1  one-cycle pulse after the final beat.
- OVERRUN  out  1  sticky: a COMMIT arrived while COMMIT_READY was low.
- WR_BANK  out  1  index of the bank currently being written.

Behaviour:
- Reset values: WR_BANK=0, state IDLE, entry pointer=0, channel pointer=0, D_VALID=0, DATA_OUT=0, D_LAST=0, FRAME_DONE=0, OVERRUN=0, COMMIT_READY=1. Memory contents are not reset.
- Write path:
  - WR_EN at a posedge stores WR_DATA into mem[WR_BANK][WR_IDX].
  - WR_IDX>=N is ignored (no write).
  - Writes are never blocked, including during CLEAR, streaming, or COMMIT.
- States:
  - IDLE: COMMIT_READY=1, D_VALID=0. COMMIT moves to STREAM.
  - On COMMIT in IDLE: WR_BANK toggles, read bank = old WR_BANK, pointers=0, state=STREAM.
  - STREAM: COMMIT_READY=0, D_VALID=1.
- First-beat latency: D_VALID rises the cycle after COMMIT is sampled.
- Stream order: entry0 ch0..ch(NCH-1), entry1 ch0..., through entry N-1. Total N*NCH beats.
- DATA_OUT = mem[read bank][entry] channel ch while D_VALID=1; 0 otherwise.
- Handshake: a beat transfers on a posedge with D_VALID&&D_READY.
  - Channel pointer increments; on NCH-1 it wraps to 0 and the entry pointer increments.
  - With D_READY=0: pointers, DATA_OUT, D_VALID and D_LAST hold.
  - D_VALID never drops without a transfer, except on CLEAR or reset.
- Final beat:
  - D_LAST=1 only when entry=N-1 and ch=NCH-1 with D_VALID=1.
  - Its transfer returns the block to IDLE; next cycle D_VALID=0, FRAME_DONE=1 for exactly one cycle, COMMIT_READY=1.
- Bank isolation: writes to the write bank during STREAM never alter DATA_OUT.
- COMMIT while COMMIT_READY=0 (including the same cycle as the last-beat transfer) is ignored and sets OVERRUN=1.
- CLEAR:
  - Next cycle: state=IDLE, pointers=0, D_VALID=0, D_LAST=0, OVERRUN=0, no FRAME_DONE.
  - WR_BANK and memory are unchanged.
  - CLEAR has priority over COMMIT and over a transfer in the same cycle.
- Reset mid-stream: all outputs return to reset values; WR_BANK=0, so later writes go to bank 0.

Test Plan (N=4, NCH=3, DW=16):
1. Basic frame:
   - Stimulus: write entry i with X=0x1000+i, Y=0x2000+i, Z=0x3000+i; pulse COMMIT; D_READY=1.
   - Response: 12 beats 1000,2000,3000,1001,...,3003. D_LAST only on 0x3003. FRAME_DONE one cycle after it. WR_BANK=1.
2. Ping-pong:
   - Stimulus: while bank0 streams, write bank1 entries with 0xA000+i / 0xB000+i / 0xC000+i.
   - Response: bank0 beats unchanged. After FRAME_DONE, COMMIT streams A000,B000,C000,...; WR_BANK=0.
3. Backpressure:
   - Stimulus: D_READY=0 for 3 cycles while beat 4 (0x2001) is presented.
   - Response: D_VALID=1 and DATA_OUT=0x2001 held. Stream resumes with 0x3001. Beat count stays 12.
4. Overrun:
   - Stimulus: COMMIT mid-stream, and COMMIT on the last-beat transfer cycle.
   - Response: both ignored, OVERRUN=1 stays set, WR_BANK unchanged. A following CLEAR clears OVERRUN.
5. CLEAR:
   - Stimulus: assert CLEAR with COMMIT and a D_READY transfer at beat 5.
   - Response: next cycle D_VALID=0, no FRAME_DONE, COMMIT_READY=1, WR_BANK unchanged.
6. Reset mid-stream:
   - Stimulus: RESET_IN=1 for one cycle at beat 7; then write entry 0 X=0x5555; then COMMIT.
   - Response: all outputs at reset values; WR_BANK=0; first beat after COMMIT is 0x5555.

Source files
------------

// File: rtl/out_buffer_pingpong.sv
// rtl/out_buffer_pingpong.sv - two-bank force output buffer; one bank fills while the other streams
module out_buffer_pingpong #(
  parameter int N        = 256,
  parameter int IDX_BITS = $clog2(N),
  parameter int DW       = 16,
  parameter int NCH      = 3
) (
  input  logic                CLK_IN,
  input  logic                RESET_IN,
  input  logic                CLEAR,
  input  logic                WR_EN,
  input  logic [IDX_BITS-1:0] WR_IDX,
  input  logic [NCH*DW-1:0]   WR_DATA,
  input  logic                COMMIT,
  output logic                COMMIT_READY,
  output logic [DW-1:0]       DATA_OUT,
  output logic                D_VALID,
  input  logic                D_READY,
  output logic                D_LAST,
  output logic                FRAME_DONE,
  output logic                OVERRUN,
  output logic                WR_BANK
);

  localparam int CH_BITS = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state_q, state_d;
  logic [IDX_BITS-1:0] ent_q, ent_d;
  logic [CH_BITS-1:0]  ch_q, ch_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q, overrun_d;

  logic [NCH*DW-1:0]   mem_q [0:1][0:N-1];
  logic [NCH*DW-1:0]   rd_word;
  logic [DW-1:0]       ch_word;
  logic                wr_ok;
  logic                last_beat;

  // Out-of-range indices only exist when N is not a power of two.
  if (2**IDX_BITS > N) begin : g_idx_chk
    assign wr_ok = (WR_IDX < IDX_BITS'(N));
  end else begin : g_idx_all
    assign wr_ok = 1'b1;
  end

  always_ff @(posedge CLK_IN) begin
    if (WR_EN && wr_ok) begin
      mem_q[wr_bank_q][WR_IDX] <= WR_DATA;
    end
  end

  assign rd_word = mem_q[rd_bank_q][ent_q];

  always_comb begin
    ch_word = '0;
    for (int c = 0; c < NCH; c++) begin
      if (int'(ch_q) == c) ch_word = rd_word[c*DW +: DW];
    end
  end

  assign D_VALID      = (state_q == STREAM);
  assign COMMIT_READY = (state_q == IDLE);
  assign last_beat    = (ent_q == IDX_BITS'(N-1)) && (ch_q == CH_BITS'(NCH-1));
  assign D_LAST       = D_VALID && last_beat;
  assign DATA_OUT     = D_VALID ? ch_word : '0;
  assign FRAME_DONE   = frame_done_q;
  assign OVERRUN      = overrun_q;
  assign WR_BANK      = wr_bank_q;

  always_comb begin
    state_d      = state_q;
    ent_d        = ent_q;
    ch_d         = ch_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    if (CLEAR) begin
      state_d   = IDLE;
      ent_d     = '0;
      ch_d      = '0;
      overrun_d = 1'b0;
    end else begin
      if (COMMIT) begin
        if (state_q == IDLE) begin
          wr_bank_d = ~wr_bank_q;
          rd_bank_d = wr_bank_q;
          ent_d     = '0;
          ch_d      = '0;
          state_d   = STREAM;
        end else begin
          overrun_d = 1'b1;
        end
      end
      if ((state_q == STREAM) && D_READY) begin
        if (last_beat) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          ent_d        = '0;
          ch_d         = '0;
        end else if (ch_q == CH_BITS'(NCH-1)) begin
          ch_d  = '0;
          ent_d = ent_q + 1'b1;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      state_q      <= IDLE;
      ent_q        <= '0;
      ch_q         <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ent_q        <= ent_d;
      ch_q         <= ch_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_out_buffer_pingpong.sv
// tb/tb_out_buffer_pingpong.sv - scoreboard bench for out_buffer_pingpong (N=4, NCH=3, DW=16)
module tb_out_buffer_pingpong;
  localparam int N = 4;
  localparam int NCH = 3;
  localparam int DW = 16;
  localparam int IB = 2;

  logic clk = 1'b0;
  logic rst, clr, wr_en, commit, d_ready;
  logic [IB-1:0] wr_idx;
  logic [NCH*DW-1:0] wr_data;
  logic commit_ready, d_valid, d_last, frame_done, overrun, wr_bank;
  logic [DW-1:0] data_out;

  always #5 clk = ~clk;

  out_buffer_pingpong #(.N(N), .IDX_BITS(IB), .DW(DW), .NCH(NCH)) dut (
    .CLK_IN(clk), .RESET_IN(rst), .CLEAR(clr), .WR_EN(wr_en), .WR_IDX(wr_idx),
    .WR_DATA(wr_data), .COMMIT(commit), .COMMIT_READY(commit_ready),
    .DATA_OUT(data_out), .D_VALID(d_valid), .D_READY(d_ready), .D_LAST(d_last),
    .FRAME_DONE(frame_done), .OVERRUN(overrun), .WR_BANK(wr_bank)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } beat_t;

  beat_t             exp_q[$];
  logic [NCH*DW-1:0] ref_mem [2][N];
  logic              ref_bank = 1'b0;
  logic              ref_ovr = 1'b0;
  logic              ref_fd = 1'b0;
  int                n_cmp = 0;
  int                n_bad = 0;
  bit                busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic bank);
    beat_t b;
    for (int e = 0; e < N; e++) begin
      for (int c = 0; c < NCH; c++) begin
        b.d    = ref_mem[bank][e][c*DW +: DW];
        b.last = (e == N-1) && (c == NCH-1);
        exp_q.push_back(b);
      end
    end
  endtask

  // Compare what the DUT presents now, then advance the frame-level model across the next edge.
  always @(negedge clk) begin
    busy = (exp_q.size() != 0);
    chk("d_valid", 64'(d_valid), 64'(busy));
    chk("commit_ready", 64'(commit_ready), 64'(!busy));
    chk("wr_bank", 64'(wr_bank), 64'(ref_bank));
    chk("overrun", 64'(overrun), 64'(ref_ovr));
    chk("frame_done", 64'(frame_done), 64'(ref_fd));
    if (busy) begin
      chk("data_out", 64'(data_out), 64'(exp_q[0].d));
      chk("d_last", 64'(d_last), 64'(exp_q[0].last));
    end else begin
      chk("data_idle", 64'(data_out), 64'd0);
      chk("d_last_idle", 64'(d_last), 64'd0);
    end

    if (wr_en) ref_mem[ref_bank][wr_idx] = wr_data;
    if (rst) begin
      exp_q.delete();
      ref_bank = 1'b0;
      ref_ovr  = 1'b0;
      ref_fd   = 1'b0;
    end else if (clr) begin
      exp_q.delete();
      ref_ovr = 1'b0;
      ref_fd  = 1'b0;
    end else begin
      ref_fd = 1'b0;
      if (busy && d_ready) begin
        ref_fd = (exp_q.size() == 1);
        void'(exp_q.pop_front());
      end
      if (commit) begin
        if (busy) ref_ovr = 1'b1;
        else begin
          push_frame(ref_bank);
          ref_bank = ~ref_bank;
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write(input int idx, input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] z);
    wr_en   = 1'b1;
    wr_idx  = IB'(idx);
    wr_data = {z, y, x};
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    cyc();
    commit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; commit = 1'b0; d_ready = 1'b0;
    wr_idx = '0; wr_data = '0;
    cyc(2);
    rst = 1'b0;
    cyc();

    // Basic frame from bank 0, while bank 1 is filled; backpressure on beat 4.
    for (int i = 0; i < N; i++) write(i, DW'(16'h1000 + i), DW'(16'h2000 + i), DW'(16'h3000 + i));
    d_ready = 1'b1;
    pulse_commit();
    for (int i = 0; i < N; i++) write(i, DW'(16'hA000 + i), DW'(16'hB000 + i), DW'(16'hC000 + i));
    d_ready = 1'b0;
    cyc(3);
    d_ready = 1'b1;
    cyc(2);
    pulse_commit();
    cyc(10);

    // Bank 1 frame; COMMIT lands on the final-beat transfer.
    pulse_commit();
    cyc(11);
    pulse_commit();
    cyc(3);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    cyc();

    // CLEAR together with COMMIT and a transfer at beat 5.
    pulse_commit();
    cyc(5);
    clr = 1'b1; commit = 1'b1;
    cyc();
    clr = 1'b0; commit = 1'b0;
    cyc(2);

    // Reset at beat 7, then a fresh frame from bank 0.
    pulse_commit();
    cyc(7);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    write(0, 16'h5555, 16'h6666, 16'h7777);
    pulse_commit();
    cyc(16);

    // Randomised traffic.
    for (int t = 0; t < 4000; t++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_idx  = IB'($urandom_range(0, N-1));
      wr_data = {$urandom(), $urandom()} [NCH*DW-1:0];
      d_ready = ($urandom_range(0, 9) < 7);
      commit  = ($urandom_range(0, 19) == 0);
      clr     = ($urandom_range(0, 149) == 0);
      rst     = ($urandom_range(0, 399) == 0);
      cyc();
    end
    wr_en = 1'b0; commit = 1'b0; clr = 1'b0; rst = 1'b0; d_ready = 1'b1;
    cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
